psum_write_arbiter: RTL and testbench
=====================================

# psum_write_arbiter

Multi-channel successor to the single-channel partial-sum buffer write controller. Up to CH processing-element channels each raise `done` when a burst of NUM_PSUM partial sums is ready in their local FIFO. The block grants one channel at a time exclusive ownership of the shared output buffer. Ownership lasts for a full burst, and the next owner is chosen by round-robin. The block drives per-channel FIFO reads, the buffer write strobe and channel select, and per-channel stalls.

## Interface
- CH, 4, number of channels (≥1)
- SEL_W, 2, width of channel index; 2^SEL_W ≥ CH
- NUM_PSUM, 8, partial sums per burst (≥1)
- CNT_W, 4, burst counter width; 2^CNT_W > NUM_PSUM-1
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- done  in  CH  per-channel burst-ready pulse/level
- valid  in  CH  per-channel FIFO holds data
- ready  in  1  output buffer accepts a write this cycle
- ren  out  CH  per-channel FIFO pop
- wen  out  1  buffer write strobe
- wsel  out  SEL_W  index of channel whose data is written
- last  out  1  marks final write of a burst (qualifies wen)
- stall  out  CH  per-channel stall to the PE
- busy  out  1  some channel owns the buffer

## Operation
- Per-channel state: IDLE, WAIT, OWN.
  - IDLE→WAIT when done[i]=1.
  - WAIT→OWN on grant.
  - OWN→IDLE on the cycle its final write occurs.
- done[i] is ignored in WAIT and OWN. It is not queued.
- Owner register: owner_vld, owner_idx. Round-robin pointer rr: the last granted index, reset to CH-1, so channel 0 wins first.
- Grant evaluation happens in any cycle where owner_vld=0, or the owner's final write occurs (fin=1).
  - Candidate set: channels in WAIT.
  - Winner: the first candidate scanning rr+1, rr+2, … modulo CH.
  - On the next edge: winner→OWN, owner_idx=winner, rr=winner, count=0.
  - With no candidate: owner_vld←0 (on fin) or stays 0.
- Write cycle: w = owner_vld & ready & valid[owner_idx].
  - wen=w; ren[owner_idx]=w; ren of all other channels is 0. No pop without a write.
  - count increments on w.
  - fin = w & (count==NUM_PSUM-1). last=fin.
  - NUM_PSUM=1 makes every write final.
- wsel=owner_idx whenever owner_vld=1, else 0.
- busy=owner_vld.
- stall[i]=1 when channel i is in WAIT, or is in OWN with !(ready & valid[i]); otherwise 0.
- Channel in IDLE: stall=0 regardless of valid.
- Arithmetic: count is unsigned CNT_W bits. It never exceeds NUM_PSUM-1; it is cleared on grant, not wrapped.

## Timing
- Reset (synchronous, highest priority): all channels IDLE, owner_vld=0, owner_idx=0, count=0, rr=CH-1.
  - Outputs ren=0, wen=0, last=0, stall=0, busy=0, wsel=0 in the cycle after the reset edge.
  - Reset mid-burst abandons the burst. No further ren/wen are issued.
- Latency, buffer free: done[i] sampled at edge t → WAIT during cycle t+1 (stall[i]=1) → OWN during t+2. The first wen is possible in t+2.
- Back-to-back handoff: if another channel is in WAIT when fin=1, the new owner writes in the very next cycle. There is zero bubble.
- The owning channel leaves OWN at the edge after fin and becomes IDLE. It can re-request with done on any later edge.
- ready or valid low while owning: wen=0, count holds, stall[owner]=1. The burst resumes with no loss.
- All outputs other than owner/count-derived state are combinational from registered state and current ready/valid.

## Test plan
- Single burst: CH=4, NUM_PSUM=8, done[2] pulse at t, valid[2]=ready=1 → stall[2]=1 at t+1; wen=1 and wsel=2 for cycles t+2..t+9; last=1 only at t+9; ren[2] pulses 8 times; busy=0 at t+10.
- Backpressure: during the burst, ready=0 for 3 cycles then ready=1, plus one valid gap → wen/ren=0 and stall=1 in those cycles; exactly 8 writes are issued and last falls on the 8th.
- Contention: done[0], done[1] and done[3] all asserted at the same edge after reset → bursts granted in order 0,1,3, each exactly 8 wen, zero idle cycles between bursts. Non-owning waiters keep stall=1.
- Fairness: channel 0 re-raises done immediately after its burst while channel 3 waits → channel 3 is granted before channel 0.
- Reset mid-burst: assert rst after the 4th write → next cycle all outputs 0. With done held low afterwards, no wen occurs. A new done[1] produces a full 8-write burst.
- NUM_PSUM=1, CH=2: done on both channels → two single-cycle writes on consecutive cycles, each with last=1.

Source files
------------

// File: rtl/psum_write_arbiter_if.sv
// Shared-buffer write handshake between the PE channels, the output buffer
// and the psum write arbiter. The arbiter takes the slave view; whatever
// drives done/valid/ready takes the master view.
interface psum_write_arbiter_if #(
  parameter int CH    = 4,
  parameter int SEL_W = 2
);
  logic [CH-1:0]    done;
  logic [CH-1:0]    valid;
  logic             ready;
  logic [CH-1:0]    ren;
  logic             wen;
  logic [SEL_W-1:0] wsel;
  logic             last;
  logic [CH-1:0]    stall;
  logic             busy;

  modport master (
    output done, valid, ready,
    input  ren, wen, wsel, last, stall, busy
  );

  modport slave (
    input  done, valid, ready,
    output ren, wen, wsel, last, stall, busy
  );
endinterface

// File: rtl/psum_write_arbiter.sv
// Round-robin arbiter granting one PE channel at a time exclusive ownership
// of the shared partial-sum output buffer for a full burst of NUM_PSUM writes.
// Each channel runs IDLE -> WAIT -> OWN; a new owner is picked whenever the
// buffer is free or the current owner performs its final write, so handoff
// between waiting channels costs no idle cycle.
module psum_write_arbiter #(
  parameter int CH       = 4,
  parameter int SEL_W    = 2,
  parameter int NUM_PSUM = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  psum_write_arbiter_if.slave  bus
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_WAIT  = 2'd1;
  localparam logic [1:0]       ST_OWN   = 2'd2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PSUM - 1);
  localparam logic [SEL_W-1:0] RR_INIT  = SEL_W'(CH - 1);

  logic [1:0]       st_q [CH];
  logic [1:0]       st_d [CH];
  logic             owner_vld_q, owner_vld_d;
  logic [SEL_W-1:0] owner_idx_q, owner_idx_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CH-1:0]    wait_s;
  logic             owner_valid_s;
  logic             w_s;
  logic             fin_s;
  logic             eval_s;
  logic             win_vld_s;
  logic [SEL_W-1:0] win_idx_s;
  logic [SEL_W:0]   pick_s;

  // First waiting channel scanning rr+1, rr+2, ... modulo CH; MSB flags a hit.
  function automatic logic [SEL_W:0] pick_winner(
    input logic [SEL_W-1:0] rr,
    input logic [CH-1:0]    cand
  );
    logic             found;
    logic [SEL_W-1:0] idx;
    int               pos;
    found = 1'b0;
    idx   = {SEL_W{1'b0}};
    for (int k = 1; k <= CH; k++) begin
      pos = (int'(rr) + k) % CH;
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = SEL_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  // Decode waiting channels, the write condition and the grant opportunity.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      wait_s[i] = (st_q[i] == ST_WAIT);
    end
    owner_valid_s = bus.valid[owner_idx_q];
    w_s           = owner_vld_q & bus.ready & owner_valid_s;
    fin_s         = w_s & (count_q == LAST_CNT);
    eval_s        = ~owner_vld_q | fin_s;
    pick_s        = pick_winner(rr_q, wait_s);
    win_vld_s     = pick_s[SEL_W];
    win_idx_s     = pick_s[SEL_W-1:0];
  end

  // State register: channel states, owner, round-robin pointer, burst count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        st_q[i] <= ST_IDLE;
      end
      owner_vld_q <= 1'b0;
      owner_idx_q <= {SEL_W{1'b0}};
      rr_q        <= RR_INIT;
      count_q     <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < CH; i++) begin
        st_q[i] <= st_d[i];
      end
      owner_vld_q <= owner_vld_d;
      owner_idx_q <= owner_idx_d;
      rr_q        <= rr_d;
      count_q     <= count_d;
    end
  end

  // Next-state: per-channel transitions, grant/handoff and burst counting.
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_idx_d = owner_idx_q;
    rr_d        = rr_q;
    count_d     = count_q;
    if (eval_s) begin
      if (win_vld_s) begin
        owner_vld_d = 1'b1;
        owner_idx_d = win_idx_s;
        rr_d        = win_idx_s;
        count_d     = {CNT_W{1'b0}};
      end else begin
        owner_vld_d = 1'b0;
        count_d     = {CNT_W{1'b0}};
      end
    end else if (w_s) begin
      count_d = count_q + CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end

    for (int i = 0; i < CH; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        ST_IDLE: st_d[i] = bus.done[i] ? ST_WAIT : ST_IDLE;
        ST_WAIT: st_d[i] = (eval_s && win_vld_s && (win_idx_s == SEL_W'(i))) ? ST_OWN : ST_WAIT;
        ST_OWN:  st_d[i] = (fin_s && (owner_idx_q == SEL_W'(i))) ? ST_IDLE : ST_OWN;
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  // Outputs: write strobe, pop, select and stalls from state plus ready/valid.
  always_comb begin
    bus.wen  = w_s;
    bus.last = fin_s;
    bus.busy = owner_vld_q;
    bus.wsel = owner_vld_q ? owner_idx_q : {SEL_W{1'b0}};
    for (int i = 0; i < CH; i++) begin
      bus.ren[i]   = w_s & (owner_idx_q == SEL_W'(i));
      bus.stall[i] = (st_q[i] == ST_WAIT) |
                     ((st_q[i] == ST_OWN) & ~(bus.ready & bus.valid[i]));
    end
  end

endmodule

// File: tb/tb_psum_write_arbiter.sv
// Directed bench for psum_write_arbiter: a CH=4/NUM_PSUM=8 instance covers
// single burst, backpressure, contention, fairness and mid-burst reset; a
// CH=2/NUM_PSUM=1 instance covers single-write bursts.
module tb_psum_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  psum_write_arbiter_if #(.CH(4), .SEL_W(2)) bus4();
  psum_write_arbiter_if #(.CH(2), .SEL_W(1)) bus2();

  psum_write_arbiter #(.CH(4), .SEL_W(2), .NUM_PSUM(8), .CNT_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  psum_write_arbiter #(.CH(2), .SEL_W(1), .NUM_PSUM(1), .CNT_W(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Reset with every input active: all outputs must read 0, done ignored.
  task automatic test_reset;
    rst = 1'b1;
    bus4.done = 4'b1111; bus4.valid = 4'b1111; bus4.ready = 1'b1;
    bus2.done = 2'b11;   bus2.valid = 2'b11;   bus2.ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus4.ren, bus4.wen, bus4.wsel, bus4.last, bus4.stall, bus4.busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs4: got %h expected %h",
               {bus4.ren, bus4.wen, bus4.wsel, bus4.last, bus4.stall, bus4.busy}, 13'd0);
    end
    checks++;
    if ({bus2.ren, bus2.wen, bus2.wsel, bus2.last, bus2.stall, bus2.busy} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs2: got %h expected %h",
               {bus2.ren, bus2.wen, bus2.wsel, bus2.last, bus2.stall, bus2.busy}, 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus4.done = 4'b0000; bus4.valid = 4'b0000; bus4.ready = 1'b0;
    bus2.done = 2'b00;   bus2.valid = 2'b00;   bus2.ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus4.stall, bus4.busy} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_idle_after: got %b expected %b", {bus4.stall, bus4.busy}, 5'b00000);
    end
  endtask

  // One burst on channel 2 with the buffer free.
  task automatic test_single_burst;
    int nren;
    nren = 0;
    @(negedge clk);
    bus4.done = 4'b0100; bus4.valid = 4'b0100; bus4.ready = 1'b1;
    @(negedge clk);
    bus4.done = 4'b0000;
    #1;
    checks++;
    if ({bus4.stall, bus4.wen, bus4.busy} !== 6'b0100_0_0) begin
      errors++;
      $display("FAIL single_wait: got %b expected %b", {bus4.stall, bus4.wen, bus4.busy}, 6'b0100_0_0);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus4.wen, bus4.wsel, bus4.last, bus4.busy, bus4.stall} !== {1'b1, 2'd2, (k == 7), 1'b1, 4'b0000}) begin
        errors++;
        $display("FAIL single_write[%0d]: got %b expected %b", k,
                 {bus4.wen, bus4.wsel, bus4.last, bus4.busy, bus4.stall},
                 {1'b1, 2'd2, (k == 7), 1'b1, 4'b0000});
      end
      if (bus4.ren == 4'b0100) nren++;
    end
    @(negedge clk);
    bus4.valid = 4'b0000;
    #1;
    checks++;
    if ({bus4.busy, bus4.wen, bus4.ren} !== 6'd0) begin
      errors++;
      $display("FAIL single_end: got %b expected %b", {bus4.busy, bus4.wen, bus4.ren}, 6'd0);
    end
    checks++;
    if (nren !== 8) begin
      errors++;
      $display("FAIL single_ren_count: got %0d expected %0d", nren, 8);
    end
  endtask

  // Channel 1 burst with 3 ready-low cycles and one valid gap.
  task automatic test_backpressure;
    logic [11:0] r_pat;
    logic [11:0] v_pat;
    logic        w;
    int          nw;
    r_pat = 12'b1111_1110_0011;
    v_pat = 12'b1111_1011_1111;
    nw = 0;
    @(negedge clk);
    bus4.done = 4'b0010; bus4.valid = 4'b0010; bus4.ready = 1'b1;
    @(negedge clk);
    bus4.done = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus4.ready = r_pat[k];
      bus4.valid = {2'b00, v_pat[k], 1'b0};
      w = r_pat[k] & v_pat[k];
      #1;
      checks++;
      if ({bus4.wen, bus4.ren, bus4.stall, bus4.last, bus4.busy} !==
          {w, 2'b00, w, 1'b0, 2'b00, ~w, 1'b0, (k == 11), 1'b1}) begin
        errors++;
        $display("FAIL bp_cycle[%0d]: got %b expected %b", k,
                 {bus4.wen, bus4.ren, bus4.stall, bus4.last, bus4.busy},
                 {w, 2'b00, w, 1'b0, 2'b00, ~w, 1'b0, (k == 11), 1'b1});
      end
      if (bus4.wen) nw++;
    end
    @(negedge clk);
    bus4.valid = 4'b0000;
    #1;
    checks++;
    if ({bus4.busy, bus4.wen} !== 2'b00 || nw !== 8) begin
      errors++;
      $display("FAIL bp_end: got busy=%b writes=%0d expected busy=0 writes=8", bus4.busy, nw);
    end
  endtask

  // Channels 0,1,3 request together after reset: served 0,1,3 back to back.
  task automatic test_contention;
    logic [1:0] exp_sel;
    logic [3:0] exp_stall;
    logic [3:0] exp_ren;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus4.done = 4'b1011; bus4.valid = 4'b1011; bus4.ready = 1'b1;
    @(negedge clk);
    bus4.done = 4'b0000;
    #1;
    checks++;
    if ({bus4.stall, bus4.busy} !== 5'b1011_0) begin
      errors++;
      $display("FAIL cont_wait: got %b expected %b", {bus4.stall, bus4.busy}, 5'b1011_0);
    end
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      #1;
      exp_sel   = (j < 8) ? 2'd0 : ((j < 16) ? 2'd1 : 2'd3);
      exp_stall = (j < 8) ? 4'b1010 : ((j < 16) ? 4'b1000 : 4'b0000);
      exp_ren   = (j < 8) ? 4'b0001 : ((j < 16) ? 4'b0010 : 4'b1000);
      checks++;
      if ({bus4.wen, bus4.wsel, bus4.ren, bus4.stall, bus4.last} !==
          {1'b1, exp_sel, exp_ren, exp_stall, ((j % 8) == 7)}) begin
        errors++;
        $display("FAIL cont_cycle[%0d]: got %b expected %b", j,
                 {bus4.wen, bus4.wsel, bus4.ren, bus4.stall, bus4.last},
                 {1'b1, exp_sel, exp_ren, exp_stall, ((j % 8) == 7)});
      end
    end
    @(negedge clk);
    bus4.valid = 4'b0000;
    #1;
    checks++;
    if ({bus4.busy, bus4.wen} !== 2'b00) begin
      errors++;
      $display("FAIL cont_end: got %b expected %b", {bus4.busy, bus4.wen}, 2'b00);
    end
  endtask

  // Channel 0 keeps requesting; waiting channel 3 must be served before it again.
  task automatic test_fairness;
    logic [1:0] exp_sel;
    logic [3:0] exp_stall;
    @(negedge clk);
    bus4.done = 4'b1001; bus4.valid = 4'b1001; bus4.ready = 1'b1;
    @(negedge clk);
    bus4.done = 4'b0001;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j == 16) bus4.done = 4'b0000;
      #1;
      exp_sel   = (j < 8) ? 2'd0 : ((j < 16) ? 2'd3 : 2'd0);
      exp_stall = (j < 8) ? 4'b1000 : ((j == 8) ? 4'b0000 : ((j < 16) ? 4'b0001 : 4'b0000));
      checks++;
      if ({bus4.wen, bus4.wsel, bus4.stall} !== {1'b1, exp_sel, exp_stall}) begin
        errors++;
        $display("FAIL fair_cycle[%0d]: got %b expected %b", j,
                 {bus4.wen, bus4.wsel, bus4.stall}, {1'b1, exp_sel, exp_stall});
      end
    end
    @(negedge clk);
    bus4.valid = 4'b0000;
    #1;
    checks++;
    if ({bus4.busy, bus4.wen} !== 2'b00) begin
      errors++;
      $display("FAIL fair_end: got %b expected %b", {bus4.busy, bus4.wen}, 2'b00);
    end
  endtask

  // Reset after the 4th write abandons the burst; a new request runs in full.
  task automatic test_reset_mid_burst;
    int nw;
    @(negedge clk);
    bus4.done = 4'b0010; bus4.valid = 4'b0010; bus4.ready = 1'b1;
    @(negedge clk);
    bus4.done = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus4.wen, bus4.wsel} !== 3'b1_01) begin
        errors++;
        $display("FAIL rmid_pre[%0d]: got %b expected %b", k, {bus4.wen, bus4.wsel}, 3'b1_01);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus4.ren, bus4.wen, bus4.wsel, bus4.last, bus4.stall, bus4.busy} !== 13'd0) begin
      errors++;
      $display("FAIL rmid_after_reset: got %h expected %h",
               {bus4.ren, bus4.wen, bus4.wsel, bus4.last, bus4.stall, bus4.busy}, 13'd0);
    end
    nw = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (bus4.wen || (bus4.ren != 4'b0000)) nw++;
    end
    checks++;
    if (nw !== 0) begin
      errors++;
      $display("FAIL rmid_no_write: got %0d writes expected %0d", nw, 0);
    end
    @(negedge clk);
    bus4.done = 4'b0010;
    @(negedge clk);
    bus4.done = 4'b0000;
    nw = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus4.wen, bus4.ren, bus4.last} !== {1'b1, 4'b0010, (k == 7)}) begin
        errors++;
        $display("FAIL rmid_burst[%0d]: got %b expected %b", k,
                 {bus4.wen, bus4.ren, bus4.last}, {1'b1, 4'b0010, (k == 7)});
      end
      if (bus4.wen) nw++;
    end
    @(negedge clk);
    bus4.valid = 4'b0000;
    #1;
    checks++;
    if ({bus4.busy, bus4.wen} !== 2'b00 || nw !== 8) begin
      errors++;
      $display("FAIL rmid_end: got busy=%b writes=%0d expected busy=0 writes=8", bus4.busy, nw);
    end
  endtask

  // NUM_PSUM=1, CH=2: two single-write bursts on consecutive cycles.
  task automatic test_single_write_bursts;
    @(negedge clk);
    bus2.done = 2'b11; bus2.valid = 2'b11; bus2.ready = 1'b1;
    @(negedge clk);
    bus2.done = 2'b00;
    #1;
    checks++;
    if ({bus2.stall, bus2.wen, bus2.busy} !== 4'b11_0_0) begin
      errors++;
      $display("FAIL np1_wait: got %b expected %b", {bus2.stall, bus2.wen, bus2.busy}, 4'b11_0_0);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus2.wen, bus2.wsel, bus2.last, bus2.ren, bus2.stall} !== 7'b1_0_1_01_10) begin
      errors++;
      $display("FAIL np1_first: got %b expected %b",
               {bus2.wen, bus2.wsel, bus2.last, bus2.ren, bus2.stall}, 7'b1_0_1_01_10);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus2.wen, bus2.wsel, bus2.last, bus2.ren, bus2.stall} !== 7'b1_1_1_10_00) begin
      errors++;
      $display("FAIL np1_second: got %b expected %b",
               {bus2.wen, bus2.wsel, bus2.last, bus2.ren, bus2.stall}, 7'b1_1_1_10_00);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus2.wen, bus2.busy, bus2.ren} !== 4'b0_0_00) begin
      errors++;
      $display("FAIL np1_end: got %b expected %b", {bus2.wen, bus2.busy, bus2.ren}, 4'b0_0_00);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_contention();
    test_fairness();
    test_reset_mid_burst();
    test_single_write_bursts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
